queue_op_scheduler: RTL and testbench
=====================================

Name: queue_op_scheduler

Overview:
- Shares one circular deque buffer among NUM_REQ requesters that issue queue operations: push_back, push_front, pop_front, pop_back.
- A round-robin arbiter picks one request per transaction. A 3-state FSM executes it and returns a tagged response.
- This is the hardware counterpart of the team's SystemVerilog queue-operation models. It sits between client blocks and a single shared storage resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width per entry.
- DEPTH, 16, deque capacity in entries; must be a power of 2.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_op  in  2*NUM_REQ  per-requester opcode; requester i uses bits [2i+1:2i].
- req_data  in  NUM_REQ*DATA_W  per-requester push data; requester i uses slice i.
- req_ready  out  NUM_REQ  one-hot grant; high for exactly one cycle.
- rsp_valid  out  1  response strobe, one cycle.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester served.
- rsp_data  out  DATA_W  popped data; 0 for pushes and errors.
- rsp_err  out  1  overflow or underflow.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset: clk rising edge with rst_n=0 clears everything.
  - state=IDLE; head=0, tail=0, count=0; rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0; req_ready=0.
  - empty=1, full=0. Storage contents are don't-care.
- Opcodes: 2'b00 PUSH_BACK, 2'b01 PUSH_FRONT, 2'b10 POP_FRONT, 2'b11 POP_BACK.
- IDLE:
  - If any req_valid is high, the arbiter picks a winner i: the first valid index at or after rr_ptr, searching circularly.
  - req_ready[i]=1 in that cycle (combinational from req_valid and rr_ptr).
  - Capture op, data and i into registers; rr_ptr <= (i+1) mod NUM_REQ; go to EXEC.
  - If no request is valid, stay in IDLE with req_ready=0.
- Requester handshake: a requester holds valid, op and data stable until it sees req_ready. It may drop valid on the next cycle.
- EXEC: perform the captured op, then go to RESP.
  - PUSH_BACK: mem[tail]=data; tail=tail+1.
  - PUSH_FRONT: head=head-1; mem[head-1]=data.
  - POP_FRONT: out=mem[head]; head=head+1.
  - POP_BACK: out=mem[tail-1]; tail=tail-1.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is incremented or decremented by 1.
- Boundary cases in EXEC:
  - Push while full: no write, no pointer or count change; err=1.
  - Pop while empty: no change; err=1; data=0.
- RESP: rsp_valid=1 for one cycle with the registered id, data and err; then go to IDLE.
  - There is no response back-pressure.
  - rsp_data and rsp_err hold their values until the next RESP; rsp_valid is 0 outside RESP.
- Latency: grant in cycle N (IDLE), execute in N+1, rsp_valid in N+2.
  - Sustained throughput is 1 operation per 3 cycles.
- Requests are ignored outside IDLE (req_ready=0).
- full, empty and count are registered and update in the cycle after EXEC, i.e. they are visible together with rsp_valid.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is issued, and all state is cleared.

Optional Feature:
- Macro: QUEUE_OP_SCHED_STATS_EN.
- When defined, adds an output port err_cnt, 16 bits.
  - Increments on every RESP with rsp_err=1 and saturates at 16'hFFFF.
  - Reset to 0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package queue_op_sched_pkg holds:
  - op_e, a 2-bit enum with the four opcodes;
  - state_e: IDLE, EXEC, RESP;
  - localparam helper functions for the pointer and count widths.
- Sub-module rr_arbiter (parameter N) takes req and ptr and returns a one-hot gnt plus a binary index. The scheduler instantiates it once.
- Storage is an inline register array.

Test Plan:
- Reset, then requester 0 issues PUSH_BACK 8'hA1 then POP_FRONT.
  - Response for the pop: rsp_id=0, rsp_data=8'hA1, rsp_err=0; count goes 1 then 0.
  - rsp_valid arrives exactly 2 cycles after req_ready.
- PUSH_BACK 1,2 then PUSH_FRONT 0, then POP_BACK, POP_FRONT, POP_FRONT.
  - Expected rsp_data: 2, 0, 1; empty=1 at the end.
- All 4 requesters hold req_valid=1 continuously.
  - Grants go 0,1,2,3,0 with rsp_id in the same order, one grant every 3 cycles.
- Push 16 entries (full=1), then PUSH_BACK 8'hFF.
  - Response: rsp_err=1, count stays 16.
  - Then 16 POP_FRONTs return the entries in push order (wrap exercised); a 17th pop returns rsp_err=1, rsp_data=0.
- Assert rst_n=0 during the EXEC of a PUSH_BACK.
  - No rsp_valid; next cycle count=0, empty=1, req_ready=0.
  - The next grant goes to requester 0.
- With QUEUE_OP_SCHED_STATS_EN defined: 3 pops on an empty deque.
  - err_cnt=3; reset returns err_cnt to 0.

Source files
------------

// File: rtl/queue_op_sched_pkg.sv
// queue_op_sched_pkg: opcodes, FSM states and width helpers for the shared deque scheduler
package queue_op_sched_pkg;
    typedef enum logic [1:0] {
        PUSH_BACK  = 2'b00,
        PUSH_FRONT = 2'b01,
        POP_FRONT  = 2'b10,
        POP_BACK   = 2'b11
    } op_e;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after ptr_i, searching circularly
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] j;
    // Walk from the farthest offset back to ptr_i so the nearest request wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                gnt_o = N'(1) << j;
                idx_o = j;
            end
        end
    end
endmodule

// File: rtl/queue_op_scheduler.sv
// queue_op_scheduler: round-robin shared deque with IDLE/EXEC/RESP transaction FSM
// Optional error counter output err_cnt under QUEUE_OP_SCHED_STATS_EN.
module queue_op_scheduler
    import queue_op_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        full,
    output logic                        empty
`ifdef QUEUE_OP_SCHED_STATS_EN
    ,
    output logic [15:0]                 err_cnt
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IW-1:0]       id_q, id_d, rr_q, rr_d, rsp_id_q, rsp_id_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d, wr_addr;
    logic [CW-1:0]       count_q, count_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d, wr_en, is_push, op_err;
    logic [NUM_REQ-1:0]  gnt;
    logic [IW-1:0]       gnt_idx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [1:0]          op_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g]   = req_op[2*g +: 2];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign is_push = !op_q[1];
    assign op_err  = is_push ? full : empty;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = |req_valid ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = state_q == IDLE ? gnt : '0;
        rsp_valid = state_q == RESP;
        rsp_id    = rsp_id_q;
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
        count     = count_q;
    end

    always_comb begin
        op_d       = op_q;
        data_d     = data_q;
        id_d       = id_q;
        rr_d       = rr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        wr_en      = 1'b0;
        wr_addr    = tail_q;
        if (state_q == IDLE && |req_valid) begin
            op_d   = op_e'(op_arr[gnt_idx]);
            data_d = data_arr[gnt_idx];
            id_d   = gnt_idx;
            rr_d   = gnt_idx == IW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
        // Overflow/underflow leaves pointers and count untouched and returns zero data
        if (state_q == EXEC) begin
            rsp_id_d   = id_q;
            rsp_err_d  = op_err;
            rsp_data_d = '0;
            if (!op_err) begin
                count_d = is_push ? count_q + 1'b1 : count_q - 1'b1;
                case (op_q)
                    PUSH_BACK: begin
                        wr_en   = 1'b1;
                        wr_addr = tail_q;
                        tail_d  = tail_q + 1'b1;
                    end
                    PUSH_FRONT: begin
                        wr_en   = 1'b1;
                        wr_addr = head_q - 1'b1;
                        head_d  = head_q - 1'b1;
                    end
                    POP_FRONT: begin
                        rsp_data_d = mem[head_q];
                        head_d     = head_q + 1'b1;
                    end
                    default: begin
                        rsp_data_d = mem[tail_q - 1'b1];
                        tail_d     = tail_q - 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= PUSH_BACK;
            data_q     <= '0;
            id_q       <= '0;
            rr_q       <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            op_q       <= op_d;
            data_q     <= data_d;
            id_q       <= id_d;
            rr_q       <= rr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem[wr_addr] <= data_q;
    end

`ifdef QUEUE_OP_SCHED_STATS_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_cnt_q <= '0;
        else if (state_q == RESP && rsp_err_q && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 1'b1;
    end
    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_queue_op_scheduler.sv
// tb_queue_op_scheduler: scoreboard bench for queue_op_scheduler, deque modelled with a SV queue
module tb_queue_op_scheduler;
    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
        logic [4:0] cnt;
        int         gc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [4:0]  count;
    logic        full;
    logic        empty;
`ifdef QUEUE_OP_SCHED_STATS_EN
    logic [15:0] err_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rr_m = 0;
    int   gcnt = 0;
    int   last_gc = -1;
    bit   chk_gap = 0;
    logic [7:0] mdl[$];
    exp_t sb[$];
    int   gq[$];

    queue_op_scheduler dut (
`ifdef QUEUE_OP_SCHED_STATS_EN
        .err_cnt   (err_cnt),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Grant watcher: checks the round-robin choice and models the deque operation
    logic [1:0] wop;
    logic [7:0] wd;
    exp_t       ne;
    always @(negedge clk) begin
        if (rst_n && req_ready != 4'b0) begin
            int w;
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && req_valid[(rr_m + k) % 4]) w = (rr_m + k) % 4;
            if (w < 0) check("gnt_none", 32'(req_ready), 32'h0);
            else begin
                check("gnt_onehot", 32'(req_ready), 32'(4'b0001 << w));
                wop = req_op[2*w +: 2];
                wd  = req_data[8*w +: 8];
                ne.id = 2'(w); ne.data = '0; ne.err = 1'b0; ne.gc = cyc;
                case (wop)
                    2'b00: if (mdl.size() == 16) ne.err = 1'b1; else mdl.push_back(wd);
                    2'b01: if (mdl.size() == 16) ne.err = 1'b1; else mdl.push_front(wd);
                    2'b10: if (mdl.size() == 0) ne.err = 1'b1; else ne.data = mdl.pop_front();
                    default: if (mdl.size() == 0) ne.err = 1'b1; else ne.data = mdl.pop_back();
                endcase
                ne.cnt = 5'(mdl.size());
                sb.push_back(ne);
                if (chk_gap && last_gc >= 0) check("gnt_gap", 32'(cyc - last_gc), 32'd3);
                last_gc = cyc;
                gq.push_back(w);
                gcnt++;
                rr_m = (w + 1) % 4;
            end
        end
    end

    exp_t me;
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) check("spurious_rsp", 32'd1, 32'd0);
            else begin
                me = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(me.id));
                check("rsp_data", 32'(rsp_data), 32'(me.data));
                check("rsp_err", 32'(rsp_err), 32'(me.err));
                check("count", 32'(count), 32'(me.cnt));
                check("full", 32'(full), 32'(me.cnt == 5'd16));
                check("empty", 32'(empty), 32'(me.cnt == 5'd0));
                check("latency", 32'(cyc - me.gc), 32'd2);
            end
        end
    end

    task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] d);
        req_op[2*id +: 2]  = op;
        req_data[8*id +: 8] = d;
        req_valid[id]      = 1'b1;
    endtask

    task automatic wait_gnt(input int id);
        bit ok;
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready[id];
        end
        if (!ok) check("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic issue(input int id, input logic [1:0] op, input logic [7:0] d);
        @(posedge clk);
        #1 set_req(id, op, d);
        wait_gnt(id);
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            check("rsp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_op(input int id, input logic [1:0] op, input logic [7:0] d);
        issue(id, op, d);
        drain();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        mdl.delete(); sb.delete(); rr_m = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(0, 2'b00, 8'hA1);
        do_op(0, 2'b10, 8'h00);

        do_op(1, 2'b00, 8'h01);
        do_op(1, 2'b00, 8'h02);
        do_op(2, 2'b01, 8'h00);
        do_op(3, 2'b11, 8'h00);
        do_op(0, 2'b10, 8'h00);
        do_op(1, 2'b10, 8'h00);
        check("deque_empty", 32'(empty), 32'd1);

        do_reset();
        gq.delete();
        chk_gap = 1; last_gc = -1;
        begin
            int g0;
            g0 = gcnt;
            @(posedge clk);
            #1 for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'(8'h10 + i));
            for (int t = 0; t < 100 && gcnt < g0 + 5; t++) @(negedge clk);
            @(posedge clk);
            #1 req_valid = '0;
            check("rr_grants", 32'(gcnt - g0), 32'd5);
        end
        chk_gap = 0;
        drain();
        begin
            int exp_ids[5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++)
                check("rr_order", 32'(i < gq.size() ? gq[i] : -1), 32'(exp_ids[i]));
        end

        do_reset();
        for (int i = 0; i < 3; i++) do_op(i, 2'b00, 8'(8'h20 + i));
        for (int i = 0; i < 3; i++) do_op(3, 2'b10, 8'h00);
        for (int i = 0; i < 16; i++) do_op(i % 4, 2'b00, 8'(8'h40 + i));
        check("full_set", 32'(full), 32'd1);
        do_op(2, 2'b00, 8'hFF);
        check("full_count", 32'(count), 32'd16);
        for (int i = 0; i < 17; i++) do_op(1, 2'b10, 8'h00);
        check("drained_empty", 32'(empty), 32'd1);

        do_op(0, 2'b00, 8'h11);
        issue(1, 2'b00, 8'h55);
        rst_n = 1'b0;
        mdl.delete(); sb.delete(); rr_m = 0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(2, 2'b00, 8'h77);
        set_req(0, 2'b00, 8'h66);
        begin
            bit ok;
            ok = 0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                ok = req_ready != 4'b0;
            end
            check("post_rst_gnt", 32'(req_ready), 32'd1);
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_gnt(2);
        drain();

`ifdef QUEUE_OP_SCHED_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) do_op(1, 2'b10, 8'h00);
        @(negedge clk);
        check("err_cnt", 32'(err_cnt), 32'd3);
        do_reset();
        @(negedge clk);
        check("err_cnt_rst", 32'(err_cnt), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
